// File: rtl/mem_access_seq.sv
// mem_access_seq: sequences instruction fetch, decode and one optional data load/store
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   start, pc                       begin an instruction at pc (accepted only in IDLE)
//   need_read, need_write           load/store request, sampled in DECODE
//   data_addr, store_data           load/store address and store value, captured in DECODE
//   mem_ready, mem_rdata            memory completion and read data
//   sig_fetch, sig_read, sig_write  one-hot access request lines
//   address, data_write             access address and store data (0 when unused)
//   instr, load_data                fetched instruction and loaded data registers
//   busy, inst_done                 not idle; one-cycle end-of-instruction pulse
//   timeout, req_err                abort reasons, pulsed together with inst_done
module mem_access_seq #(
    parameter int WORD_SIZE = 16,
    parameter int MAX_WAIT  = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] pc,
    input  logic                 need_read,
    input  logic                 need_write,
    input  logic [WORD_SIZE-1:0] data_addr,
    input  logic [WORD_SIZE-1:0] store_data,
    input  logic                 mem_ready,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 sig_fetch,
    output logic                 sig_read,
    output logic                 sig_write,
    output logic [WORD_SIZE-1:0] address,
    output logic [WORD_SIZE-1:0] data_write,
    output logic [WORD_SIZE-1:0] instr,
    output logic [WORD_SIZE-1:0] load_data,
    output logic                 busy,
    output logic                 inst_done,
    output logic                 timeout,
    output logic                 req_err
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, READ, WRITE, DONE} state_t;

    state_t               state, state_d;
    logic [WORD_SIZE-1:0] pc_q, addr_q, sdata_q;
    logic [WW-1:0]        wait_cnt;
    logic                 to_flag, err_flag;
    logic                 access, expired;

    assign access  = state == FETCH || state == READ || state == WRITE;
    // mem_ready in the last allowed cycle takes priority over the abort
    assign expired = access && !mem_ready && wait_cnt == WW'(MAX_WAIT - 1);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:        state_d = start ? FETCH : IDLE;
            FETCH:       state_d = mem_ready ? DECODE : expired ? DONE : FETCH;
            DECODE:      state_d = (need_read ^ need_write) ? (need_read ? READ : WRITE) : DONE;
            READ, WRITE: state_d = (mem_ready || expired) ? DONE : state;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pc_q      <= '0;
            addr_q    <= '0;
            sdata_q   <= '0;
            instr     <= '0;
            load_data <= '0;
            wait_cnt  <= '0;
            to_flag   <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            state    <= state_d;
            // staying in the same access state counts a wait; any transition starts fresh
            wait_cnt <= (access && state_d == state) ? wait_cnt + 1'b1 : '0;
            if (state == IDLE && start) pc_q <= pc;
            if (state == DECODE) begin
                addr_q  <= data_addr;
                sdata_q <= store_data;
            end
            if (state == FETCH && mem_ready) instr <= mem_rdata;
            if (state == READ && mem_ready) load_data <= mem_rdata;
            to_flag  <= expired || (to_flag && state != DONE);
            err_flag <= (state == DECODE && need_read && need_write) || (err_flag && state != DONE);
        end
    end

    assign sig_fetch  = state == FETCH;
    assign sig_read   = state == READ;
    assign sig_write  = state == WRITE;
    assign address    = sig_fetch ? pc_q : (sig_read || sig_write) ? addr_q : '0;
    assign data_write = sig_write ? sdata_q : '0;
    assign busy       = state != IDLE;
    assign inst_done  = state == DONE;
    assign timeout    = inst_done && to_flag;
    assign req_err    = inst_done && err_flag;
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: table-driven, scoreboarded bench for mem_access_seq
module tb_mem_access_seq;
    logic        clk = 1'b0;
    logic        reset_n, start, need_read, need_write, mem_ready;
    logic [15:0] pc, data_addr, store_data, mem_rdata;
    logic        sig_fetch, sig_read, sig_write, busy, inst_done, timeout, req_err;
    logic [15:0] address, data_write, instr, load_data;

    int checks = 0;
    int failures = 0;

    mem_access_seq #(.WORD_SIZE(16), .MAX_WAIT(15)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pc(pc),
        .need_read(need_read), .need_write(need_write),
        .data_addr(data_addr), .store_data(store_data),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .sig_fetch(sig_fetch), .sig_read(sig_read), .sig_write(sig_write),
        .address(address), .data_write(data_write),
        .instr(instr), .load_data(load_data),
        .busy(busy), .inst_done(inst_done), .timeout(timeout), .req_err(req_err)
    );

    always #5 clk = ~clk;

    // flat/dlat: cycle of the access on which memory answers, 0 = never
    typedef struct {
        logic [15:0] pc, rdi;
        int          flat;
        logic        nr, nw;
        logic [15:0] daddr, sdata;
        int          dlat;
        logic [15:0] rdd;
        logic        bstart;
        logic [15:0] e_instr, e_load;
        logic        e_to, e_err;
        int          e_f, e_r, e_w;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, {29'b0, sig_fetch, sig_read, sig_write}, 32'd0);
        chk({tag, "_addr"}, 32'(address), 32'd0);
        chk({tag, "_wdata"}, 32'(data_write), 32'd0);
        chk({tag, "_instr"}, 32'(instr), 32'd0);
        chk({tag, "_load"}, 32'(load_data), 32'd0);
        chk({tag, "_flags"}, {28'b0, busy, inst_done, timeout, req_err}, 32'd0);
    endtask

    task automatic run(input vec_t v);
        int en, fc, rc, wc;
        logic pf, pd, pr, pw, pn;
        logic [15:0] ea;
        vec_t e;
        fc = 0; rc = 0; wc = 0;
        en = v.e_f + ((v.flat == 0) ? 1 : 2 + v.e_r + v.e_w);
        @(negedge clk);
        pc = v.pc;
        start = 1'b1;
        sb.push_back(v);
        for (int n = 1; n <= en; n++) begin
            @(negedge clk);
            pf = n <= v.e_f;
            pd = v.flat != 0 && n == v.e_f + 1;
            pr = v.e_r > 0 && n > v.e_f + 1 && n < en;
            pw = v.e_w > 0 && n > v.e_f + 1 && n < en;
            pn = n == en;
            ea = pf ? v.pc : (pr || pw) ? v.daddr : 16'h0000;
            chk("req", {29'b0, sig_fetch, sig_read, sig_write}, {29'b0, pf, pr, pw});
            chk("addr", 32'(address), 32'(ea));
            chk("wdata", 32'(data_write), pw ? 32'(v.sdata) : 32'd0);
            chk("status", {28'b0, busy, inst_done, timeout, req_err},
                {28'b0, 1'b1, pn, pn && v.e_to, pn && v.e_err});
            if (inst_done) begin
                chk("sb_pending", 32'(sb.size()), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("instr", 32'(instr), 32'(e.e_instr));
                    chk("load_data", 32'(load_data), 32'(e.e_load));
                end
            end
            start = v.bstart;
            pc = 16'($urandom);
            need_read = pd ? v.nr : 1'($urandom);
            need_write = pd ? v.nw : 1'($urandom);
            data_addr = pd ? v.daddr : 16'($urandom);
            store_data = pd ? v.sdata : 16'($urandom);
            mem_rdata = 16'($urandom);
            if (sig_fetch) begin
                fc++;
                mem_ready = fc == v.flat;
                if (mem_ready) mem_rdata = v.rdi;
            end else if (sig_read) begin
                rc++;
                mem_ready = rc == v.dlat;
                if (mem_ready) mem_rdata = v.rdd;
            end else if (sig_write) begin
                wc++;
                mem_ready = wc == v.dlat;
            end else begin
                mem_ready = 1'b1;
            end
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clk);
        chk("idle_after", {30'b0, busy, inst_done}, 32'd0);
        start = 1'b0;
    endtask

    initial begin
        tbl[0] = '{16'h0010, 16'hF01C, 1,  1'b0, 1'b0, 16'h0000, 16'h0000, 0,  16'h0000, 1'b0,
                   16'hF01C, 16'h0000, 1'b0, 1'b0, 1,  0,  0};
        tbl[1] = '{16'h0011, 16'hA001, 1,  1'b1, 1'b0, 16'h0042, 16'h0000, 3,  16'h1234, 1'b1,
                   16'hA001, 16'h1234, 1'b0, 1'b0, 1,  3,  0};
        tbl[2] = '{16'h0012, 16'hB002, 1,  1'b0, 1'b1, 16'h0080, 16'hBEEF, 1,  16'h0000, 1'b0,
                   16'hB002, 16'h1234, 1'b0, 1'b0, 1,  0,  1};
        tbl[3] = '{16'h0013, 16'hDEAD, 0,  1'b1, 1'b0, 16'h0050, 16'h0000, 1,  16'h9999, 1'b1,
                   16'hB002, 16'h1234, 1'b1, 1'b0, 15, 0,  0};
        tbl[4] = '{16'h0014, 16'hC00F, 15, 1'b0, 1'b0, 16'h0000, 16'h0000, 0,  16'h0000, 1'b0,
                   16'hC00F, 16'h1234, 1'b0, 1'b0, 15, 0,  0};
        tbl[5] = '{16'h0015, 16'hD0D0, 2,  1'b1, 1'b1, 16'h0060, 16'h5555, 1,  16'h7777, 1'b0,
                   16'hD0D0, 16'h1234, 1'b0, 1'b1, 2,  0,  0};
        tbl[6] = '{16'h0016, 16'hE0E0, 1,  1'b1, 1'b0, 16'h0099, 16'h0000, 0,  16'h0000, 1'b1,
                   16'hE0E0, 16'h1234, 1'b1, 1'b0, 1,  15, 0};
        tbl[7] = '{16'h0017, 16'h1111, 1,  1'b1, 1'b0, 16'h00AA, 16'h0000, 15, 16'h5A5A, 1'b0,
                   16'h1111, 16'h5A5A, 1'b0, 1'b0, 1,  15, 0};
        tbl[8] = '{16'h0018, 16'h2222, 1,  1'b0, 1'b1, 16'h00BB, 16'h7777, 2,  16'h0000, 1'b1,
                   16'h2222, 16'h5A5A, 1'b0, 1'b0, 1,  0,  2};

        reset_n = 1'b0; start = 1'b0; pc = '0; need_read = 1'b0; need_write = 1'b0;
        data_addr = '0; store_data = '0; mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk);
        chk_zero("rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_zero("post_rst");

        for (int i = 0; i < 9; i++) run(tbl[i]);

        // reset in the middle of a stalled load
        @(negedge clk);
        pc = 16'h0200; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h3333;
        @(negedge clk);
        mem_ready = 1'b0; need_read = 1'b1; need_write = 1'b0; data_addr = 16'h0300;
        @(negedge clk);
        chk("mid_read", {31'b0, sig_read}, 32'd1);
        chk("mid_addr", 32'(address), 32'h0300);
        chk("mid_instr", 32'(instr), 32'h3333);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_zero("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold", {30'b0, busy, inst_done}, 32'd0);
        end
        reset_n = 1'b1; need_read = 1'b0;
        @(negedge clk);
        chk_zero("rst_release");
        run(tbl[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Sequences memory traffic for one instruction.
- On `start`, it fetches the instruction at the captured PC and latches it into `instr`. It then gives the datapath one decode cycle to request a data load or store, and performs that access.
- Drives the `sig_fetch`/`sig_read`/`sig_write` request lines, address and write data into the memory I/O stage. Consumes that stage's `data_out` and the memory completion flag.
- Signals completion to the control unit, and aborts any access that exceeds a wait budget.

Parameters:
- WORD_SIZE, 16, data/address width (matches `WORD_SIZE` from opcodes.v).
- MAX_WAIT, 15, maximum cycles one access may stay outstanding before timeout (≥1).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  begin new instruction; sampled only in IDLE.
- pc  input  WORD_SIZE  instruction address; captured when start accepted.
- need_read  input  1  datapath requests a load; sampled in DECODE.
- need_write  input  1  datapath requests a store; sampled in DECODE.
- data_addr  input  WORD_SIZE  load/store address; captured in DECODE.
- store_data  input  WORD_SIZE  store value; captured in DECODE.
- mem_ready  input  1  memory completion of the current access.
- mem_rdata  input  WORD_SIZE  read data returned by the memory I/O stage.
- sig_fetch  output  1  instruction-fetch request.
- sig_read  output  1  data-read request.
- sig_write  output  1  data-write request.
- address  output  WORD_SIZE  access address.
- data_write  output  WORD_SIZE  store data.
- instr  output  WORD_SIZE  fetched instruction register.
- load_data  output  WORD_SIZE  loaded data register.
- busy  output  1  high in every state except IDLE.
- inst_done  output  1  one-cycle pulse at end of instruction.
- timeout  output  1  one-cycle pulse with inst_done when an access aborted.
- req_err  output  1  one-cycle pulse with inst_done when both need_read and need_write were high in DECODE.

Behaviour:
- **Reset:** asynchronous. State=IDLE. All outputs, `instr`, `load_data`, captured registers and `wait_cnt` are 0. Reset mid-access drops the request lines immediately; no done pulse is issued.
- **States:** IDLE, FETCH, DECODE, READ, WRITE, DONE.
- **Request outputs:** Moore-decoded from state.
  - FETCH: `sig_fetch=1`.
  - READ: `sig_read=1`.
  - WRITE: `sig_write=1`.
  - Otherwise all three are 0. At most one is ever high.
- **Address / write data:**
  - `address` = captured PC in FETCH, captured `data_addr` in READ/WRITE, 0 otherwise.
  - `data_write` = captured `store_data` in WRITE, 0 otherwise.
- **IDLE:** if `start`, capture `pc` and go to FETCH. `start` in any other state is ignored.
- **FETCH / READ / WRITE (access states):**
  - `wait_cnt` is cleared on entry.
  - At each posedge, if `mem_ready`=1, the access completes:
    - FETCH: `instr` ← `mem_rdata`, go to DECODE.
    - READ: `load_data` ← `mem_rdata`, go to DONE.
    - WRITE: go to DONE.
  - Else if `wait_cnt`==MAX_WAIT-1: abort, set timeout flag, go to DONE. `instr`/`load_data` are unchanged.
  - Else `wait_cnt` increments.
  - Minimum access latency is 1 cycle; maximum is MAX_WAIT cycles. `mem_ready` in the final allowed cycle wins over timeout.
- **DECODE:** exactly one cycle. Capture `data_addr` and `store_data`, then:
  - `need_read` & `need_write` → set req_err flag, go to DONE (no access).
  - `need_read` only → READ.
  - `need_write` only → WRITE.
  - neither → DONE.
- **DONE:**
  - `inst_done`=1 for this cycle.
  - `timeout` and `req_err` reflect their flags this cycle.
  - Flags clear; next state is IDLE.
  - A `start` asserted during DONE is ignored; it must be held into IDLE.
- **Throughput:**
  - Minimum for a no-data instruction: IDLE→FETCH→DECODE→DONE→IDLE, 4 cycles with 1-cycle memory.
  - Minimum for a load/store: 5 cycles.
- `instr` and `load_data` hold their values until overwritten by a successful access.
- `wait_cnt` width is `$clog2(MAX_WAIT+1)`; it never wraps.
- `mem_ready` outside access states is ignored.

Test Plan:
- **Plain fetch.** reset_n low then high; pc=16'h0010, start for 1 cycle; mem_ready=1 at first FETCH cycle with mem_rdata=16'hF01C; need_read=need_write=0.
  - → address=16'h0010 with sig_fetch for 1 cycle; instr=16'hF01C; inst_done on cycle 3 after start; busy for 3 cycles.
- **Load with delayed memory.** Fetch completes; in DECODE need_read=1, data_addr=16'h0042; mem_ready asserted on 3rd READ cycle with mem_rdata=16'h1234.
  - → sig_read high exactly 3 cycles at address 16'h0042; load_data=16'h1234; inst_done pulse; timeout=0.
- **Store.** need_write=1, data_addr=16'h0080, store_data=16'hBEEF, mem_ready on first cycle.
  - → sig_write 1 cycle, address=16'h0080, data_write=16'hBEEF; data_write returns to 0 after.
- **Timeout.** MAX_WAIT=15, mem_ready held 0 during FETCH.
  - → sig_fetch high 15 cycles, then inst_done and timeout pulse together; instr unchanged.
  - Repeat with mem_ready on cycle 15 → completes normally, no timeout.
- **Conflicting request.** need_read=need_write=1 in DECODE.
  - → no sig_read/sig_write; req_err and inst_done pulse together next cycle.
- **Reset mid-access and ignored start.** reset_n low during READ wait.
  - → sig_read drops asynchronously, all outputs 0, no inst_done.
  - Also: start asserted while busy has no effect.
